wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-back port arbiter for the superscalar core. It arbitrates among up to NUM_REQ completing execution units (ALU0, ALU1, MEM, MUL/DIV) for the single write port of `register_file`, using a round-robin policy. It registers the winning result and drives `reg_write`, `Write_reg` and `Write_Data` one cycle after acceptance. It sits between the functional-unit result buses and the register file.

## Interface
Reset is synchronous and active-high. The block uses one clock, `clk`, and one reset, `rst`.

Parameters:
- NUM_REQ, 4, number of requesting units (2..8)
- ADDR, 5, register index width
- WIDTH, 32, data width

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-unit result valid
- req_rd  in  NUM_REQ×ADDR  per-unit destination register
- req_data  in  NUM_REQ×WIDTH  per-unit result
- req_ready  out  NUM_REQ  one-hot or zero; result of unit i accepted this cycle when req_valid[i] && req_ready[i]
- wb_stall  in  1  downstream hold; no acceptance while high
- reg_write  out  1  register-file write enable
- Write_reg  out  ADDR  register-file write index
- Write_Data  out  WIDTH  register-file write data
- wb_valid  out  1  a result was accepted last cycle, including writes to x0
- wb_src  out  $clog2(NUM_REQ)  index of the unit whose result is on the outputs

## Operation
- Priority pointer `ptr` (0..NUM_REQ-1) sets arbitration order.
  - Search starts at `ptr` and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins.
- Grant is combinational: req_ready[win]=1, all other bits 0.
  - No grant when wb_stall=1 or no valid request.
- Requesters must not make req_valid depend on req_ready.
- Once asserted, req_valid, req_rd and req_data must stay stable until the transfer.
- On transfer by unit i, ptr <= (i+1) mod NUM_REQ. Without a transfer, ptr holds.
- Output stage, registered on every edge:
  - wb_valid <= transfer
  - reg_write <= transfer && req_rd[win] != 0
  - Write_reg <= req_rd[win]
  - Write_Data <= req_data[win]
  - wb_src <= win
- Write_reg, Write_Data and wb_src hold their previous values when there is no transfer.
- Writes to x0 are accepted and consume the slot (wb_valid=1, reg_write=0), so the requester is never blocked on x0.
- Two units targeting the same rd in one cycle: only the winner is written this cycle; the loser is written on a later cycle. Program-order correctness is the ROB's responsibility, not this block's.
- Fairness: with wb_stall=0, a continuously valid requester is granted within NUM_REQ-1 cycles.

## Timing
- Acceptance-to-write latency: 1 cycle. reg_write is high during the cycle after the transfer, and the register file captures the data on the following edge.
- Throughput: 1 result per cycle with no bubbles between back-to-back grants.
- wb_stall=1 at cycle N:
  - req_ready=0 in cycle N.
  - reg_write=0 and wb_valid=0 in cycle N+1.
  - Pending requests stay held.
- Reset (rst=1 at an edge):
  - ptr=0, reg_write=0, wb_valid=0, Write_reg=0, Write_Data=0, wb_src=0.
  - req_ready=0 while rst is high.
- Reset mid-operation: the in-flight output write is dropped (reg_write=0 in the next cycle). Unaccepted requests are not lost; they remain the requesters' responsibility.
- ptr wrap: after a grant to unit NUM_REQ-1, ptr becomes 0.

## Structure
- Package `wb_arb_pkg`:
  - NUM_REQ default
  - REQ_ID_W = $clog2(NUM_REQ)
  - struct `wb_req_t` {rd, data}
  - struct `wb_out_t` {valid, we, rd, data, src}
- Sub-module `rr_arbiter` (NUM_REQ):
  - Inputs: request vector, enable, accept.
  - Outputs: one-hot grant and winner index.
  - Owns `ptr`.
- The top level instantiates `rr_arbiter`, the data mux and the output register.

## Test plan
- Reset, then a single request from unit 2 (rd=5, data=0xDEADBEEF): req_ready[2]=1 in the same cycle; next cycle reg_write=1, Write_reg=5, Write_Data=0xDEADBEEF, wb_src=2; ptr becomes 3.
- All 4 units valid continuously for 8 cycles starting from ptr=0: grant order 0,1,2,3,0,1,2,3; reg_write high on every cycle from cycle 1 to cycle 8.
- Unit 1 writes rd=0: wb_valid=1, reg_write=0, and unit 1 is released.
- wb_stall=1 for 3 cycles while units 0 and 3 are valid: no req_ready, reg_write=0 from the following cycle; after release, unit 0 is granted, then unit 3.
- Units 1 and 3 both target rd=7 with data 0x11 and 0x33 and ptr=2: unit 3 writes first (0x33), then unit 1 (0x11) the next cycle.
- rst asserted in the cycle after a grant: reg_write=0 on the next cycle, ptr=0, all outputs 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and default sizing for the write-back port arbiter.
// The structs are sized from the package defaults.
package wb_arb_pkg;
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int ADDR_DEFAULT    = 5;
  localparam int WIDTH_DEFAULT   = 32;
  localparam int REQ_ID_W        = $clog2(NUM_REQ_DEFAULT);

  typedef struct packed {
    logic [ADDR_DEFAULT-1:0]  rd;
    logic [WIDTH_DEFAULT-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic [ADDR_DEFAULT-1:0]  rd;
    logic [WIDTH_DEFAULT-1:0] data;
    logic [REQ_ID_W-1:0]      src;
  } wb_out_t;
endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Round-robin arbiter that owns the priority pointer.
// The pointer advances only on an accepted grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    win
);
  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] win_s;
  logic            found_s;

  // Search for the first valid request starting at ptr, wrapping around
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    win_s   = ptr_r;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req[ID_W'(idx)]) begin
        found_s = 1'b1;
        win_s   = ID_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant for the winner when arbitration is enabled
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    if (enable && found_s) begin
      grant[win_s] = 1'b1;
    end else begin
      grant = {NUM_REQ{1'b0}};
    end
  end

  // Priority pointer moves just past the unit that transferred
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {ID_W{1'b0}};
    end else if (accept) begin
      ptr_r <= (win_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : win_s + ID_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign win = win_s;
endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: round-robin selection of one completing unit
// per cycle, registered onto the single register-file write port.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ADDR    = ADDR_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][ADDR-1:0]  req_rd,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wb_stall,
  output logic                          reg_write,
  output logic [ADDR-1:0]               Write_reg,
  output logic [WIDTH-1:0]              Write_Data,
  output logic                          wb_valid,
  output logic [$clog2(NUM_REQ)-1:0]    wb_src
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    win_s;
  logic               xfer_s;
  logic               enable_s;
  wb_req_t            sel_s;
  wb_out_t            out_r;

  // Grants are suppressed during reset so no request is consumed then
  assign enable_s = !wb_stall && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .enable (enable_s),
    .accept (xfer_s),
    .grant  (grant_s),
    .win    (win_s)
  );

  assign req_ready = grant_s;
  assign xfer_s    = |(req_valid & grant_s);

  // Winner data mux
  always_comb begin
    sel_s.rd   = req_rd[win_s];
    sel_s.data = req_data[win_s];
  end

  // Output register; x0 writes consume the slot but keep reg_write low
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= '{valid: 1'b0, we: 1'b0, rd: {ADDR{1'b0}}, data: {WIDTH{1'b0}}, src: {ID_W{1'b0}}};
    end else begin
      out_r.valid <= xfer_s;
      out_r.we    <= xfer_s && (sel_s.rd != ADDR'(0));
      if (xfer_s) begin
        out_r.rd   <= sel_s.rd;
        out_r.data <= sel_s.data;
        out_r.src  <= win_s;
      end else begin
        out_r.rd   <= out_r.rd;
        out_r.data <= out_r.data;
        out_r.src  <= out_r.src;
      end
    end
  end

  assign wb_valid   = out_r.valid;
  assign reg_write  = out_r.we;
  assign Write_reg  = out_r.rd;
  assign Write_Data = out_r.data;
  assign wb_src     = out_r.src;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a cycle-level reference model
// derived from the round-robin rules, checked on every falling edge.
module tb_wb_port_arbiter;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wb_stall = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][4:0]   req_rd = '0;
  logic [N-1:0][31:0]  req_data = '0;
  logic [N-1:0]        req_ready;
  logic                reg_write;
  logic [4:0]          Write_reg;
  logic [31:0]         Write_Data;
  logic                wb_valid;
  logic [1:0]          wb_src;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  bit refill = 1'b0;
  int refill_cnt = 0;

  // reference model state
  int          m_ptr = 0;
  int          last_acc = -1;
  bit          e_valid = 1'b0;
  bit          e_we = 1'b0;
  logic [4:0]  e_reg = '0;
  logic [31:0] e_data = '0;
  int          e_src = 0;
  int          src_log[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(.NUM_REQ(N), .ADDR(5), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .wb_stall(wb_stall), .reg_write(reg_write), .Write_reg(Write_reg),
    .Write_Data(Write_Data), .wb_valid(wb_valid), .wb_src(wb_src)
  );

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[2'((p + k) % N)] === 1'b1) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: what the port must present after each edge
  always @(posedge clk) begin
    int w;
    w = pick(req_valid, m_ptr);
    last_acc = -1;
    if (rst) begin
      m_ptr = 0; e_valid = 1'b0; e_we = 1'b0; e_reg = '0; e_data = '0; e_src = 0;
    end else begin
      e_valid = 1'b0;
      e_we = 1'b0;
      if (!wb_stall && w >= 0) begin
        e_valid  = 1'b1;
        e_we     = (req_rd[2'(w)] != 5'd0);
        e_reg    = req_rd[2'(w)];
        e_data   = req_data[2'(w)];
        e_src    = w;
        m_ptr    = (w + 1) % N;
        last_acc = w;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      int w;
      logic [N-1:0] er;
      w = pick(req_valid, m_ptr);
      er = '0;
      if (!rst && !wb_stall && w >= 0) er[2'(w)] = 1'b1;
      check("req_ready", req_ready, er);
      check("wb_valid", wb_valid, e_valid);
      check("reg_write", reg_write, e_we);
      check("Write_reg", Write_reg, e_reg);
      check("Write_Data", Write_Data, e_data);
      check("wb_src", wb_src, e_src);
      if (wb_valid === 1'b1) src_log.push_back(int'(wb_src));
    end
  end

  task automatic post(input int u, input logic [4:0] rd, input logic [31:0] d);
    req_valid[2'(u)] = 1'b1;
    req_rd[2'(u)]    = rd;
    req_data[2'(u)]  = d;
  endtask

  // one clock; requesters drop (or renew) what was accepted at that edge
  task automatic step();
    @(posedge clk);
    #1;
    if (last_acc >= 0) begin
      req_valid[2'(last_acc)] = 1'b0;
      if (refill) begin
        refill_cnt++;
        post(last_acc, 5'(8 + last_acc), 32'(refill_cnt));
      end
    end
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && req_valid != '0; i++) step();
    check("drain_timeout", req_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk_on = 1'b1;
    rst = 1'b0;
  endtask

  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    // reset state and single request from unit 2
    do_reset();
    mid();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_Write_Data", Write_Data, 0);
    post(2, 5'd5, 32'hDEADBEEF);
    #1;
    check("t1_ready", req_ready, 4'b0100);
    step();
    mid();
    check("t1_reg_write", reg_write, 1);
    check("t1_Write_reg", Write_reg, 5);
    check("t1_Write_Data", Write_Data, 32'hDEADBEEF);
    check("t1_wb_src", wb_src, 2);
    check("t1_ptr", m_ptr, 3);

    // four units continuously valid from ptr 0
    do_reset();
    src_log.delete();
    for (int u = 0; u < N; u++) post(u, 5'(8 + u), 32'(u));
    refill = 1'b1;
    repeat (7) step();
    refill = 1'b0;
    step();
    mid();
    check("t2_count", src_log.size(), 8);
    for (int i = 0; i < 8 && i < src_log.size(); i++) check("t2_order", src_log[i], exp_order[i]);
    drain();

    // write to x0 consumes the slot without a register write
    post(1, 5'd0, 32'h1234);
    #1;
    check("t3_ready", req_ready, 4'b0010);
    step();
    mid();
    check("t3_wb_valid", wb_valid, 1);
    check("t3_reg_write", reg_write, 0);
    check("t3_wb_src", wb_src, 1);
    check("t3_released", req_ready, 0);

    // stall holds units 0 and 3, then 0 goes first
    do_reset();
    wb_stall = 1'b1;
    post(0, 5'd3, 32'hA0);
    post(3, 5'd4, 32'hA3);
    src_log.delete();
    repeat (3) begin
      mid();
      check("t4_stall_ready", req_ready, 0);
      step();
    end
    mid();
    check("t4_reg_write", reg_write, 0);
    check("t4_wb_valid", wb_valid, 0);
    wb_stall = 1'b0;
    drain();
    mid();
    check("t4_count", src_log.size(), 2);
    if (src_log.size() == 2) begin
      check("t4_first", src_log[0], 0);
      check("t4_second", src_log[1], 3);
    end

    // same rd from units 1 and 3 with ptr at 2
    post(1, 5'd9, 32'h55);
    drain();
    check("t5_ptr", m_ptr, 2);
    post(1, 5'd7, 32'h11);
    post(3, 5'd7, 32'h33);
    step();
    mid();
    check("t5_src_a", wb_src, 3);
    check("t5_data_a", Write_Data, 32'h33);
    check("t5_reg_a", Write_reg, 7);
    step();
    mid();
    check("t5_src_b", wb_src, 1);
    check("t5_data_b", Write_Data, 32'h11);
    check("t5_we_b", reg_write, 1);

    // reset in the cycle after a grant, with another request waiting
    post(0, 5'd6, 32'hC0);
    step();
    post(2, 5'd10, 32'hC2);
    rst = 1'b1;
    #1;
    check("t6_ready_in_rst", req_ready, 0);
    mid();
    check("t6_write_visible", reg_write, 1);
    step();
    rst = 1'b0;
    mid();
    check("t6_reg_write", reg_write, 0);
    check("t6_wb_valid", wb_valid, 0);
    check("t6_Write_Data", Write_Data, 0);
    check("t6_Write_reg", Write_reg, 0);
    check("t6_wb_src", wb_src, 0);
    check("t6_ptr", m_ptr, 0);
    check("t6_ready_after", req_ready, 4'b0100);
    step();
    mid();
    check("t6_late_src", wb_src, 2);
    check("t6_late_reg", Write_reg, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
